// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier MAC datapath.
package matmul_pkg;

    // Default operand width of the multiply stage
    localparam int DEF_DATA_WIDTH = 8;

    // Register stages between operand acceptance and product output
    localparam int PIPE_LATENCY = 3;

    // Per-transaction arithmetic mode
    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

endpackage : matmul_pkg

// File: rtl/vedicmultiplier_core.sv
// Combinational W x W -> 2W unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
// Built recursively from four W/2 instances down to a 2-bit leaf.
module vedicmultiplier_core #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    generate
        if (W == 2) begin : g_leaf
            // 2x2 leaf: vertical and crosswise bit products with half adders
            logic t_lh;
            logic t_hl;
            logic t_hh;
            logic k1;

            assign t_lh = a[1] & b[0];
            assign t_hl = a[0] & b[1];
            assign t_hh = a[1] & b[1];
            assign k1   = t_lh & t_hl;

            assign p[0] = a[0] & b[0];
            assign p[1] = t_lh ^ t_hl;
            assign p[2] = t_hh ^ k1;
            assign p[3] = t_hh & k1;
        end else begin : g_node
            localparam int HW = W / 2;

            logic [W-1:0] pp_hh;
            logic [W-1:0] pp_lh;
            logic [W-1:0] pp_hl;
            logic [W-1:0] pp_ll;
            logic [W:0]   mid;

            vedicmultiplier_core #(.W(HW)) u_hh (
                .a (a[W-1:HW]),
                .b (b[W-1:HW]),
                .p (pp_hh)
            );

            vedicmultiplier_core #(.W(HW)) u_lh (
                .a (a[HW-1:0]),
                .b (b[W-1:HW]),
                .p (pp_lh)
            );

            vedicmultiplier_core #(.W(HW)) u_hl (
                .a (a[W-1:HW]),
                .b (b[HW-1:0]),
                .p (pp_hl)
            );

            vedicmultiplier_core #(.W(HW)) u_ll (
                .a (a[HW-1:0]),
                .b (b[HW-1:0]),
                .p (pp_ll)
            );

            // Crosswise sum keeps its carry, then everything lands in 2W bits
            assign mid = {1'b0, pp_lh} + {1'b0, pp_hl};
            assign p   = {pp_hh, {W{1'b0}}}
                       + {{(HW-1){1'b0}}, mid, {HW{1'b0}}}
                       + {{W{1'b0}}, pp_ll};
        end
    endgenerate

endmodule : vedicmultiplier_core

// File: rtl/vedicmultiplier_pipe.sv
// Three-stage pipelined Vedic multiplier with unsigned/signed mode and
// valid/ready handshake on both sides (bubble-collapsing backpressure).
// S1: operand magnitudes + result sign, S2: four half-width partial
// products, S3: combine, apply sign, register product.
module vedicmultiplier_pipe
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic                      inMode,
    input  logic [DATA_WIDTH-1:0]     inData_A,
    input  logic [DATA_WIDTH-1:0]     inData_B,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [2*DATA_WIDTH-1:0]   outData_C
);

    localparam int N = DATA_WIDTH;
    localparam int H = DATA_WIDTH / 2;

    // Magnitude of a two's complement value; the most negative value maps
    // to 2^(N-1), which still fits in N unsigned bits.
    function automatic logic [N-1:0] abs_mag(input logic signed [N-1:0] x);
        logic [N-1:0] r;
        if (x[N-1]) begin
            r = (~$unsigned(x)) + {{(N-1){1'b0}}, 1'b1};
        end else begin
            r = $unsigned(x);
        end
        return r;
    endfunction

    // Conditional two's complement negation of the 2N-bit product
    function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v,
                                                  input logic           neg);
        logic [2*N-1:0] r;
        if (neg) begin
            r = (~v) + {{(2*N-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Handshake / stage control
    logic rdy_en;
    logic vld_p1;
    logic vld_p2;
    logic vld_p3;
    logic en_p1;
    logic en_p2;
    logic en_p3;
    logic in_fire;

    // Stage data
    logic [N-1:0]   mag_a_p0;
    logic [N-1:0]   mag_b_p0;
    logic           sgn_p0;
    logic [N-1:0]   mag_a_p1;
    logic [N-1:0]   mag_b_p1;
    logic           sgn_p1;
    logic [N-1:0]   pp_hh;
    logic [N-1:0]   pp_lh;
    logic [N-1:0]   pp_hl;
    logic [N-1:0]   pp_ll;
    logic [N-1:0]   pp_hh_p2;
    logic [N-1:0]   pp_lh_p2;
    logic [N-1:0]   pp_hl_p2;
    logic [N-1:0]   pp_ll_p2;
    logic           sgn_p2;
    logic [N:0]     mid_p2;
    logic [2*N-1:0] sum_p2;
    logic [2*N-1:0] prod_p3;

    // A stage may load when it is empty or its content is moving on
    assign en_p3   = !vld_p3 || outReady;
    assign en_p2   = !vld_p2 || en_p3;
    assign en_p1   = !vld_p1 || en_p2;
    assign inReady = rdy_en && en_p1;
    assign in_fire = inValid && inReady;

    assign outValid  = vld_p3;
    assign outData_C = prod_p3;

    // Keeps inReady low through reset until the first clock edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // ---- S1 input: magnitudes and sign (zero operands force sign 0) ----
    always_comb begin
        mag_a_p0 = inData_A;
        mag_b_p0 = inData_B;
        sgn_p0   = 1'b0;
        if (inMode == MODE_SIGNED) begin
            mag_a_p0 = abs_mag($signed(inData_A));
            mag_b_p0 = abs_mag($signed(inData_B));
            sgn_p0   = (inData_A[N-1] ^ inData_B[N-1]) && (|inData_A) && (|inData_B);
        end
    end

    // S1 register: operand magnitudes and result sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            mag_a_p1 <= '0;
            mag_b_p1 <= '0;
            sgn_p1   <= 1'b0;
        end else if (en_p1) begin
            vld_p1 <= in_fire;
            if (in_fire) begin
                mag_a_p1 <= mag_a_p0;
                mag_b_p1 <= mag_b_p0;
                sgn_p1   <= sgn_p0;
            end
        end
    end

    // ---- S2 input: four half-width crosswise partial products ----
    vedicmultiplier_core #(.W(H)) u_pp_hh (
        .a (mag_a_p1[N-1:H]),
        .b (mag_b_p1[N-1:H]),
        .p (pp_hh)
    );

    vedicmultiplier_core #(.W(H)) u_pp_lh (
        .a (mag_a_p1[H-1:0]),
        .b (mag_b_p1[N-1:H]),
        .p (pp_lh)
    );

    vedicmultiplier_core #(.W(H)) u_pp_hl (
        .a (mag_a_p1[N-1:H]),
        .b (mag_b_p1[H-1:0]),
        .p (pp_hl)
    );

    vedicmultiplier_core #(.W(H)) u_pp_ll (
        .a (mag_a_p1[H-1:0]),
        .b (mag_b_p1[H-1:0]),
        .p (pp_ll)
    );

    // S2 register: partial products and forwarded sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            pp_hh_p2 <= '0;
            pp_lh_p2 <= '0;
            pp_hl_p2 <= '0;
            pp_ll_p2 <= '0;
            sgn_p2   <= 1'b0;
        end else if (en_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                pp_hh_p2 <= pp_hh;
                pp_lh_p2 <= pp_lh;
                pp_hl_p2 <= pp_hl;
                pp_ll_p2 <= pp_ll;
                sgn_p2   <= sgn_p1;
            end
        end
    end

    // ---- S3 input: combine partial products; middle sum keeps its carry ----
    assign mid_p2 = {1'b0, pp_lh_p2} + {1'b0, pp_hl_p2};
    assign sum_p2 = {pp_hh_p2, {N{1'b0}}}
                  + {{(H-1){1'b0}}, mid_p2, {H{1'b0}}}
                  + {{N{1'b0}}, pp_ll_p2};

    // S3 register: signed product; holds its value while no new product arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p3  <= 1'b0;
            prod_p3 <= '0;
        end else if (en_p3) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                prod_p3 <= apply_sign(sum_p2, sgn_p2);
            end
        end
    end

endmodule : vedicmultiplier_pipe

// File: tb/tb_vedicmultiplier_pipe.sv
// Scoreboard bench for vedicmultiplier_pipe at DATA_WIDTH=8.
module tb_vedicmultiplier_pipe;
    import matmul_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           inValid = 1'b0;
    logic           inReady;
    logic           inMode = 1'b0;
    logic [W-1:0]   inData_A = '0;
    logic [W-1:0]   inData_B = '0;
    logic           outValid;
    logic           outReady = 1'b0;
    logic [2*W-1:0] outData_C;

    always #5 clk = ~clk;

    vedicmultiplier_pipe #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .inMode    (inMode),
        .inData_A  (inData_A),
        .inData_B  (inData_B),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData_C (outData_C)
    );

    int             n_checks = 0;
    int             n_fail = 0;
    logic [2*W-1:0] sb_q[$];
    int             cyc = 0;
    int             n_acc = 0;
    int             n_out = 0;
    int             acc_cyc = 0;
    int             out_cyc = 0;
    int             first_out_cyc = -1;
    logic [2*W-1:0] last_out = '0;
    logic [2*W-1:0] held = '0;
    bit             stall_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic m, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int ia;
        int ib;
        int p;
        ia = m ? int'($signed(a)) : int'(a);
        ib = m ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return p[2*W-1:0];
    endfunction

    // One clock cycle: drive, sample at negedge, score, advance past posedge
    task automatic step(input logic v, input logic m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy);
        inValid  = v;
        inMode   = m;
        inData_A = a;
        inData_B = b;
        outReady = ordy;
        @(negedge clk);
        if (stall_prev) begin
            check_val("hold_valid", 32'(outValid), 32'd1);
            check_val("hold_data", 32'(outData_C), 32'(held));
        end
        stall_prev = outValid && !outReady;
        held       = outData_C;
        if (inValid && inReady) begin
            sb_q.push_back(ref_mul(m, a, b));
            n_acc++;
            acc_cyc = cyc;
        end
        if (outValid && outReady) begin
            n_out++;
            out_cyc  = cyc;
            last_out = outData_C;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (sb_q.size() == 0) begin
                check_val("unexpected_out_valid", 32'(outValid), 32'd0);
            end else begin
                check_val("sb_data", 32'(outData_C), 32'(sb_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < budget) begin
            step(1'b0, 1'b0, '0, '0, 1'b1);
            k++;
        end
        if (sb_q.size() != 0) check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int a0;
        int n0;
        int na0;

        // Reset state
        #3;
        check_val("rst_inReady", 32'(inReady), 32'd0);
        check_val("rst_outValid", 32'(outValid), 32'd0);
        check_val("rst_outData", 32'(outData_C), 32'd0);
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("inReady_after_rst", 32'(inReady), 32'd1);

        // Unsigned max and latency
        step(1'b1, MODE_UNSIGNED, 8'd255, 8'd255, 1'b1);
        a0 = acc_cyc;
        drain(10);
        check_val("latency", 32'(out_cyc - a0), 32'(PIPE_LATENCY));
        check_val("u_255x255", 32'(last_out), 32'h0000_FE01);

        // Signed corner cases
        step(1'b1, MODE_SIGNED, 8'h80, 8'h80, 1'b1);
        drain(10);
        check_val("s_80x80", 32'(last_out), 32'h0000_4000);
        step(1'b1, MODE_SIGNED, 8'hFF, 8'h7F, 1'b1);
        drain(10);
        check_val("s_FFx7F", 32'(last_out), 32'h0000_FF81);
        step(1'b1, MODE_SIGNED, 8'h80, 8'h01, 1'b1);
        drain(10);
        check_val("s_80x01", 32'(last_out), 32'h0000_FF80);
        step(1'b1, MODE_SIGNED, 8'h00, 8'h85, 1'b1);
        drain(10);
        check_val("s_zero", 32'(last_out), 32'h0000_0000);

        // Back-to-back random mixed-mode stream
        n0 = n_out;
        first_out_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'b1);
        end
        drain(10);
        check_val("stream_count", 32'(n_out - n0), 32'd16);
        check_val("stream_consecutive", 32'(out_cyc - first_out_cyc), 32'd15);

        // Backpressure: outReady low for 6 cycles with inValid held high
        na0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'b0);
        end
        check_val("bp_accepts", 32'(n_acc - na0), 32'd3);
        check_val("bp_inReady", 32'(inReady), 32'd0);
        check_val("bp_outValid", 32'(outValid), 32'd1);
        drain(20);

        // Bubbles with toggling outReady
        for (int i = 0; i < 24; i++) begin
            step((i % 2) == 0, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), (i % 4) < 2);
        end
        drain(20);
        check_val("bubble_in_out_count", 32'(n_out), 32'(n_acc));

        // Asynchronous reset with products in flight
        for (int i = 0; i < 3; i++) begin
            step(1'b1, MODE_UNSIGNED, 8'd3, 8'(5 + i), 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_outValid", 32'(outValid), 32'd0);
        check_val("arst_outData", 32'(outData_C), 32'd0);
        check_val("arst_inReady", 32'(inReady), 32'd0);
        sb_q.delete();
        stall_prev = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        step(1'b1, MODE_UNSIGNED, 8'd7, 8'd9, 1'b1);
        drain(10);
        check_val("post_rst_7x9", 32'(last_out), 32'd63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_vedicmultiplier_pipe
